// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the two-requester RAM arbiter.
// State encoding and default bus widths / timeout.
package ram_arb_pkg;

  localparam int ARB_ADDR_W  = 32;
  localparam int ARB_DATA_W  = 64;
  localparam int ARB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: counts BUSY cycles of one RAM transaction.
// Ports: clk, rst (async low), clear, enable, limit -> expired.
module arb_timeout_counter
  import ram_arb_pkg::*;
#(
  parameter  int TIMEOUT = ARB_TIMEOUT,
  localparam int CW      = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == limit);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin share of one RAM port by two requesters,
// one transaction in flight, per-transaction timeout with err pulse.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] rdata,
  output logic              ready0,
  output logic              ready1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic              owner,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_address,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_in
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  arb_state_e        state_q;
  logic              last_q;
  logic              owner_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rdy_q;
  logic [1:0]        err_q;

  logic gnt;
  logic grant;
  logic in_busy;
  logic expired;

  // Tie goes to whoever was not served last.
  assign gnt     = (req0 & req1) ? ~last_q : req1;
  assign grant   = (state_q == ST_IDLE) & (req0 | req1);
  assign in_busy = (state_q == ST_BUSY);

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .enable  (in_busy),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      rdy_q   <= '0;
      err_q   <= '0;
    end else begin
      rdy_q <= '0;
      err_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant) begin
            addr_q  <= gnt ? addr1 : addr0;
            owner_q <= gnt;
            req_q   <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Data arriving on the last allowed cycle beats the timeout.
          if (ram_ready | expired) begin
            rdata_q        <= ram_ready ? ram_in : '0;
            rdy_q[owner_q] <= 1'b1;
            err_q[owner_q] <= ~ram_ready;
            last_q         <= owner_q;
            req_q          <= 1'b0;
            state_q        <= ST_RELEASE;
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign ready0      = rdy_q[0];
  assign ready1      = rdy_q[1];
  assign err0        = err_q[0];
  assign err1        = err_q[1];
  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;
  assign ram_req     = req_q;
  assign ram_address = addr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed + random stimulus for ram_arbiter,
// checked every cycle against a transaction-level model.
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic          ram_ready = 1'b0;
  logic [DW-1:0] ram_in = '0;

  logic [DW-1:0] rdata;
  logic          ready0, ready1, err0, err1;
  logic          busy, owner, ram_req;
  logic [AW-1:0] ram_address;

  ram_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .addr0       (addr0),
    .req1        (req1),
    .addr1       (addr1),
    .rdata       (rdata),
    .ready0      (ready0),
    .ready1      (ready1),
    .err0        (err0),
    .err1        (err1),
    .busy        (busy),
    .owner       (owner),
    .ram_req     (ram_req),
    .ram_address (ram_address),
    .ram_ready   (ram_ready),
    .ram_in      (ram_in)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: transaction phase (0 free, 1 waiting on RAM, 2 handing
  // back), number of RAM wait cycles used, and last served index.
  int            m_phase;
  int            m_used;
  int            m_last;
  logic          e_req, e_owner;
  logic [1:0]    e_rdy, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_rdata;
  int            grant_log[$];

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_used  = 0;
    m_last  = 1;
    e_req   = 1'b0;
    e_owner = 1'b0;
    e_rdy   = '0;
    e_err   = '0;
    e_addr  = '0;
    e_rdata = '0;
  endtask

  task automatic model_step();
    int who;
    if (!rst) begin
      model_reset();
      return;
    end
    e_rdy = '0;
    e_err = '0;
    if (m_phase == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) who = 1 - m_last;
        else              who = req1 ? 1 : 0;
        grant_log.push_back(who);
        e_owner = who[0];
        e_addr  = who ? addr1 : addr0;
        e_req   = 1'b1;
        m_used  = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_used++;
      if (ram_ready || m_used == TO) begin
        e_rdata        = ram_ready ? ram_in : '0;
        e_rdy[e_owner] = 1'b1;
        e_err[e_owner] = !ram_ready;
        m_last         = e_owner;
        e_req          = 1'b0;
        m_phase        = 2;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic compare();
    check("ram_req", ram_req, e_req);
    check("ram_address", ram_address, e_addr);
    check("rdata", rdata, e_rdata);
    check("ready0", ready0, e_rdy[0]);
    check("ready1", ready1, e_rdy[1]);
    check("err0", err0, e_err[0]);
    check("err1", err1, e_err[1]);
    check("owner", owner, e_owner);
    check("busy", busy, m_phase != 0);
    check("ready_excl", ready0 & ready1, 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b1;
  endtask

  // Wait for grant, hold RAM off for lat-1 cycles, answer with d.
  task automatic run_txn(input int lat,
                         input logic [DW-1:0] d,
                         output int who);
    int k;
    k   = 0;
    who = -1;
    while (!ram_req && k < 10) begin
      cycle();
      k++;
    end
    check("grant_wait", ram_req, 1);
    if (!ram_req) return;
    repeat (lat - 1) cycle();
    ram_ready = 1'b1;
    ram_in    = d;
    cycle();
    ram_ready = 1'b0;
    if (ready0) begin
      who  = 0;
      req0 = 1'b0;
    end else if (ready1) begin
      who  = 1;
      req1 = 1'b0;
    end
    check("txn_data", rdata, d);
    check("txn_noerr", err0 | err1, 0);
    check("txn_req_drop", ram_req, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    int who;
    int n;
    int exp_seq[6];
    exp_seq = '{0, 1, 0, 1, 0, 1};

    @(negedge clk);
    do_reset();

    // Single request from 0, RAM answers on 3rd wait cycle.
    req0  = 1'b1;
    addr0 = 32'h100;
    run_txn(3, 64'hDEAD_BEEF, who);
    check("t1_who", who, 0);
    check("t1_addr", ram_address, 32'h100);
    check("t1_rdata", rdata, 64'hDEAD_BEEF);
    check("t1_ready1", ready1, 0);
    cycle();
    check("t1_idle_req", ram_req, 0);
    check("t1_idle_busy", busy, 0);

    // Simultaneous first requests after reset: 0 goes first.
    do_reset();
    req0  = 1'b1;
    addr0 = 32'h10;
    req1  = 1'b1;
    addr1 = 32'h20;
    run_txn(2, 64'h1111, who);
    check("t2_first", who, 0);
    check("t2_addr0", ram_address, 32'h10);
    run_txn(2, 64'h2222, who);
    check("t2_second", who, 1);
    check("t2_addr1", ram_address, 32'h20);

    // Both held continuously: strict alternation.
    grant_log.delete();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_txn(1 + i, 64'h5000 + 64'(i), who);
      check("t3_who", who, exp_seq[i]);
      if (who == 0) req0 = 1'b1;
      if (who == 1) req1 = 1'b1;
    end
    check("t3_log_len", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("t3_log", grant_log[i], exp_seq[i]);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) cycle();

    // Timeout on requester 1.
    req1  = 1'b1;
    addr1 = 32'h300;
    n = 0;
    while (!ram_req && n < 10) begin
      cycle();
      n++;
    end
    n = 0;
    while (ram_req && n < 40) begin
      n++;
      cycle();
    end
    check("t4_busy_cycles", n, 16);
    check("t4_ready1", ready1, 1);
    check("t4_err1", err1, 1);
    check("t4_rdata", rdata, 0);
    check("t4_ready0", ready0, 0);
    req1 = 1'b0;
    cycle();
    check("t4_idle", busy, 0);

    // Data on the very last allowed cycle wins over timeout.
    req1 = 1'b1;
    run_txn(16, 64'hABCD_0123_4567_89EF, who);
    check("t5_who", who, 1);
    check("t5_err1", err1, 0);
    cycle();

    // Async reset in the middle of a transaction.
    req0  = 1'b1;
    addr0 = 32'h440;
    n = 0;
    while (!ram_req && n < 10) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    check("t6_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("t6_req", ram_req, 0);
    check("t6_busy", busy, 0);
    check("t6_rdy", {ready0, ready1}, 0);
    check("t6_err", {err0, err1}, 0);
    check("t6_addr", ram_address, 0);
    req0 = 1'b0;
    cycle();
    rst       = 1'b1;
    ram_ready = 1'b1;
    ram_in    = 64'h7777;
    repeat (3) begin
      cycle();
      check("t6_late_rdy", {ready0, ready1}, 0);
    end
    ram_ready = 1'b0;

    // Random traffic: fast RAM first, then a slow one with timeouts.
    for (int c = 0; c < 3000; c++) begin
      ram_ready = ($urandom_range(c < 1500 ? 2 : 24, 0) == 0);
      ram_in    = {$urandom, $urandom};
      cycle();
      if (req0 && ready0) req0 = 1'b0;
      else if (!req0 && $urandom_range(3, 0) == 0) begin
        req0  = 1'b1;
        addr0 = $urandom;
      end
      if (req1 && ready1) req1 = 1'b0;
      else if (!req1 && $urandom_range(3, 0) == 0) begin
        req1  = 1'b1;
        addr1 = $urandom;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
